// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM state type, default plane count and RGB plane-bit slicer for the HUB75 column driver
package hub75_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;

    localparam int RGB_RES_DEF = 9;
    localparam int BPC = RGB_RES_DEF / 3;

    // Pixel word layout is {R, G, B}, each bpc bits wide; returns {r, g, b} bit b of each channel.
    function automatic logic [2:0] plane_bits(input logic [31:0] word, input int bpc, input int b);
        return {word[2*bpc+b], word[bpc+b], word[b]};
    endfunction

endpackage

// File: rtl/hub75_column_driver_timer.sv
// bcm_on_timer: times one BCM display window of BASE_ON<<plane cycles and gates OE within it
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         start a new window for plane_i (brightness sampled here when enabled)
//   run_i          window in progress (counts while high)
//   plane_i        current bit plane
//   bright_i       8-bit brightness, only with HUB75_BRIGHTNESS_EN defined
//   oe_o           panel should be lit this cycle
//   done_o         last cycle of the window
module bcm_on_timer #(
    parameter int BASE_ON = 8,
    parameter int PLANES  = 3,
    parameter int PW      = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          run_i,
    input  logic [PW-1:0] plane_i,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]    bright_i,
`endif
    output logic          oe_o,
    output logic          done_o
);
    localparam int TW = $clog2((BASE_ON << (PLANES - 1)) + 1);

    logic [TW-1:0] cnt_q, cnt_d, len_q, len_d;

    assign len_d  = TW'(BASE_ON) << plane_i;
    assign cnt_d  = load_i ? '0 : run_i ? cnt_q + 1'b1 : cnt_q;
    assign done_o = run_i && cnt_q == len_q - 1'b1;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= load_i ? len_d : len_q;
        end

`ifdef HUB75_BRIGHTNESS_EN
    logic [TW-1:0]   thr_q, thr_d;
    logic [TW+7:0]   prod;

    // Lit portion of the window scales with brightness; the window itself keeps its length.
    assign prod  = {8'b0, len_d} * {{TW{1'b0}}, bright_i};
    assign thr_d = prod[TW+7:8];
    assign oe_o  = run_i && cnt_q < thr_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) thr_q <= '0;
        else       thr_q <= load_i ? thr_d : thr_q;
`else
    assign oe_o = run_i;
`endif

endmodule

// File: rtl/hub75_column_driver.sv
// hub75_column_driver: fetches a column pair, snapshots it and scans it out to a HUB75 panel with BCM
//   clk_in, rst_in      clock, asynchronous active-high reset
//   enable_in           run the scan; checked in IDLE and at each address end
//   brightness_in       8-bit OE duty, only with HUB75_BRIGHTNESS_EN defined
//   columns             column pair returned for column_index1/column_index2
//   column_index1/2     requested column (top/bottom half)
//   rgb0/rgb1           serial {r,g,b} data for top/bottom half
//   panel_clk/lat/oe_n  HUB75 shift clock, latch, active-low output enable
//   panel_addr          HUB75 row address
//   frame_done          one-cycle pulse after the last plane of the last address
module hub75_column_driver
    import hub75_pkg::*;
#(
    parameter int SCAN_RATE = 32,
    parameter int NUM_ROWS  = 64,
    parameter int RGB_RES   = 3 * BPC,
    parameter int BASE_ON   = 8
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  enable_in,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                            brightness_in,
`endif
    input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns,
    output logic [$clog2(SCAN_RATE)-1:0]          column_index1,
    output logic [$clog2(SCAN_RATE)-1:0]          column_index2,
    output logic [2:0]                            rgb0,
    output logic [2:0]                            rgb1,
    output logic                                  panel_clk,
    output logic                                  panel_lat,
    output logic                                  panel_oe_n,
    output logic [$clog2(SCAN_RATE)-1:0]          panel_addr,
    output logic                                  frame_done
);
    localparam int AW     = $clog2(SCAN_RATE);
    localparam int SW     = $clog2(2 * NUM_ROWS);
    localparam int RW     = $clog2(NUM_ROWS);
    localparam int PLANES = RGB_RES / 3;
    localparam int PW     = $clog2(PLANES + 1);

    state_t                                 state_q, state_d;
    logic [SW-1:0]                          cnt_q, cnt_d;
    logic [PW-1:0]                          plane_q, plane_d;
    logic [AW-1:0]                          scan_q, scan_d, idx_q, idx_d, addr_q, addr_d;
    logic                                   frame_q, frame_d;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  buf_q, buf_d;
    logic [RW-1:0]                          pix;
    logic                                   tm_load, tm_oe, tm_done;

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            plane_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            frame_q <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            plane_q <= plane_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            frame_q <= frame_d;
            buf_q   <= buf_d;
        end

    // cnt_q counts FETCH cycles, then SHIFT half-cycles (bit 0 is the panel clock phase).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        plane_d = plane_q;
        scan_d  = scan_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        frame_d = 1'b0;
        tm_load = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = enable_in ? FETCH : IDLE;
                cnt_d   = '0;
            end
            FETCH: begin
                cnt_d = cnt_q + 1'b1;
                idx_d = cnt_q == '0 ? scan_q : idx_q;
                if (cnt_q == SW'(2)) begin
                    buf_d   = columns;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SW'(2 * NUM_ROWS - 1)) begin
                    state_d = LATCH;
                    addr_d  = scan_q;
                end
            end
            LATCH: begin
                tm_load = 1'b1;
                state_d = DISPLAY;
            end
            DISPLAY: if (tm_done) begin
                cnt_d = '0;
                if (plane_q != PW'(PLANES - 1)) begin
                    plane_d = plane_q + 1'b1;
                    state_d = SHIFT;
                end else begin
                    plane_d = '0;
                    frame_d = scan_q == AW'(SCAN_RATE - 1);
                    scan_d  = frame_d ? '0 : scan_q + 1'b1;
                    state_d = enable_in ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bcm_on_timer #(
        .BASE_ON (BASE_ON),
        .PLANES  (PLANES),
        .PW      (PW)
    ) u_timer (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .load_i   (tm_load),
        .run_i    (state_q == DISPLAY),
        .plane_i  (plane_q),
`ifdef HUB75_BRIGHTNESS_EN
        .bright_i (brightness_in),
`endif
        .oe_o     (tm_oe),
        .done_o   (tm_done)
    );

    // Highest pixel goes out first; each pixel occupies a low and a high clock phase.
    assign pix           = RW'(NUM_ROWS - 1) - cnt_q[SW-1:1];
    assign rgb0          = state_q == SHIFT ? plane_bits(32'(buf_q[0][pix]), PLANES, int'(plane_q)) : 3'b0;
    assign rgb1          = state_q == SHIFT ? plane_bits(32'(buf_q[1][pix]), PLANES, int'(plane_q)) : 3'b0;
    assign panel_clk     = state_q == SHIFT && cnt_q[0];
    assign panel_lat     = state_q == LATCH;
    assign panel_oe_n    = !tm_oe;
    assign panel_addr    = addr_q;
    assign column_index1 = idx_q;
    assign column_index2 = idx_q;
    assign frame_done    = frame_q;

endmodule

// File: tb/tb_hub75_column_driver.sv
// tb_hub75_column_driver: randomized column data checked against a frame-level scan model
module tb_hub75_column_driver;
    localparam int SR = 32, N = 64, RR = 9, BO = 8, NP = RR / 3, AW = 5;
    localparam int FRAME = SR * (3 + NP * (2 * N + 1) + BO * ((1 << NP) - 1));
`ifdef HUB75_BRIGHTNESS_EN
    localparam int BR = 128;
    logic [7:0] brightness_in = 8'd128;
`else
    localparam int BR = 256;
`endif

    logic clk_in = 1'b0, rst_in = 1'b1, enable_in = 1'b0;
    logic [1:0][N-1:0][RR-1:0] columns;
    logic [AW-1:0] column_index1, column_index2, panel_addr;
    logic [2:0] rgb0, rgb1;
    logic panel_clk, panel_lat, panel_oe_n, frame_done;

    logic [1:0][N-1:0][RR-1:0] colmem [SR];
    logic [1:0][N-1:0][RR-1:0] snap;
    logic [3*N-1:0] line0, line1;
    int total = 0, bad = 0;
    int cyc = 0, nbits = 0, oe_len = 0, m_addr = 0, m_plane = 0, last_fd = 0, nfd = 0, nlat = 0;
    bit mon_en = 0, fd_valid = 0, fd_due = 0, oe_prev = 1, pclk_prev = 0;

    always #5 clk_in = ~clk_in;

    always_comb begin
        columns[0] = colmem[column_index1][0];
        columns[1] = colmem[column_index2][1];
    end

    hub75_column_driver dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .enable_in     (enable_in),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness_in (brightness_in),
`endif
        .columns       (columns),
        .column_index1 (column_index1),
        .column_index2 (column_index2),
        .rgb0          (rgb0),
        .rgb1          (rgb1),
        .panel_clk     (panel_clk),
        .panel_lat     (panel_lat),
        .panel_oe_n    (panel_oe_n),
        .panel_addr    (panel_addr),
        .frame_done    (frame_done)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial line for one half and plane, first shifted pixel in the top bits.
    function automatic logic [3*N-1:0] exp_line(input int h, input int b);
        logic [3*N-1:0] l = '0;
        logic [RR-1:0] w;
        for (int i = 0; i < N; i++) begin
            w = snap[h][N-1-i];
            l[3*(N-1-i) +: 3] = {w[2*NP+b], w[NP+b], w[b]};
        end
        return l;
    endfunction

    task automatic scramble(input int a);
        for (int h = 0; h < 2; h++)
            for (int p = 0; p < N; p++) colmem[a][h][p] = RR'($urandom);
    endtask

    // One clock of observation: collect shifted bits, check each latched line,
    // each OE window and frame_done against the address/plane model.
    task automatic tick();
        @(negedge clk_in);
        cyc++;
        if (!enable_in) fd_valid = 0;
        if (mon_en) begin
            if (panel_clk && !pclk_prev) begin
                if (nbits == 0 && m_plane == 0) begin
                    snap = colmem[m_addr];
                    if (m_addr == 5 || $urandom_range(3) == 0) scramble(m_addr);
                end
                line0 = {line0[3*N-4:0], rgb0};
                line1 = {line1[3*N-4:0], rgb1};
                nbits++;
            end
            if (panel_lat) begin
                chk("shift_count", 256'(nbits), 256'(N));
                chk("row_top", 256'(line0), 256'(exp_line(0, m_plane)));
                chk("row_bot", 256'(line1), 256'(exp_line(1, m_plane)));
                nbits = 0;
                nlat++;
            end
            if (!panel_oe_n) oe_len++;
            if (panel_oe_n && !oe_prev) begin
                chk("oe_window", 256'(oe_len), 256'(((BO << m_plane) * BR) >> 8));
                chk("panel_addr", 256'(panel_addr), 256'(m_addr));
                oe_len = 0;
                if (m_plane == NP - 1) begin
                    m_plane = 0;
                    m_addr = (m_addr + 1) % SR;
                    fd_due = m_addr == 0;
                end else m_plane++;
            end
            if (frame_done) begin
                chk("frame_done_pos", 256'(fd_due), 256'(1));
                if (fd_valid) chk("frame_len", 256'(cyc - last_fd), 256'(FRAME));
                fd_due = 0;
                last_fd = cyc;
                fd_valid = 1;
                nfd++;
            end
        end
        pclk_prev = panel_clk;
        oe_prev = panel_oe_n;
    endtask

    initial begin
        int n, a_next;
        for (int a = 0; a < SR; a++) scramble(a);
        colmem[0] = '0;
        colmem[0][0][N-1] = 9'b001_000_000;

        repeat (5) tick();
        chk("rst_oe_n", 256'(panel_oe_n), 256'(1));
        chk("rst_outs", 256'({rgb0, rgb1, panel_clk, panel_lat, frame_done, panel_addr, column_index1, column_index2}), 256'(0));
        rst_in = 1'b0;
        n = 0;
        repeat (100) begin
            tick();
            if (!panel_oe_n || panel_clk || panel_lat || frame_done || rgb0 != 0 || rgb1 != 0 || panel_addr != 0) n++;
        end
        chk("idle_after_reset", 256'(n), 256'(0));

        mon_en = 1;
        enable_in = 1'b1;
        for (int i = 0; i < 500 && nlat == 0; i++) tick();
        chk("first_latch_seen", 256'(nlat), 256'(1));
        chk("first_pixel_top", 256'(line0[3*N-1 -: 3]), 256'(3'b100));
        chk("first_line_bot", 256'(line1), 256'(0));

        for (int i = 0; i < 3 * FRAME && nfd < 2; i++) tick();
        chk("two_frames_seen", 256'(nfd >= 2), 256'(1));

        for (int i = 0; i < 2000 && !(m_plane == 1 && !panel_oe_n); i++) tick();
        chk("plane1_window_seen", 256'(m_plane == 1 && !panel_oe_n), 256'(1));
        repeat (3) tick();
        enable_in = 1'b0;
        for (int i = 0; i < 2000 && m_plane != 0; i++) tick();
        chk("address_completed", 256'(m_plane), 256'(0));
        a_next = m_addr;
        n = 0;
        repeat (200) begin
            tick();
            if (panel_clk || !panel_oe_n || panel_lat) n++;
        end
        chk("idle_after_drop", 256'(n), 256'(0));
        enable_in = 1'b1;
        for (int i = 0; i < 1000 && panel_oe_n; i++) tick();
        chk("resume_addr", 256'(panel_addr), 256'(a_next));

        for (int i = 0; i < 1000 && !panel_clk; i++) tick();
        chk("shift_before_reset", 256'(panel_clk), 256'(1));
        mon_en = 0;
        #3 rst_in = 1'b1;
        #1;
        chk("async_oe_n", 256'(panel_oe_n), 256'(1));
        chk("async_outs", 256'({rgb0, rgb1, panel_clk, panel_lat, frame_done, panel_addr, column_index1, column_index2}), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
